// File: rtl/hack_pc_stage_if.sv
// Bundle between execute, the PC stage and instruction fetch.
// slave = the PC stage's view; master = the surrounding pipeline's view.
interface hack_pc_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             is_c;
  logic [2:0]       jmp;
  logic             alu_zr;
  logic             alu_ng;
  logic [WIDTH-1:0] target;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] pc;
  logic             taken;
  logic             flush;

  modport slave (
    input  in_valid, is_c, jmp, alu_zr, alu_ng, target, out_ready,
    output in_ready, out_valid, pc, taken, flush
  );

  modport master (
    output in_valid, is_c, jmp, alu_zr, alu_ng, target, out_ready,
    input  in_ready, out_valid, pc, taken, flush
  );
endinterface

// File: rtl/hack_pc_stage.sv
// Hack program-counter stage: jump decision, next fetch address, jump-to-self halt.
// Optional saturating taken-branch counter behind HACK_PC_BRANCH_CNT_EN.
module hack_pc_stage #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  hack_pc_stage_if.slave       bus,
  output logic                 halted
`ifdef HACK_PC_BRANCH_CNT_EN
  ,
  output logic [WIDTH-1:0]     branch_cnt
`endif
);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_q, issued_q, pc_nxt;
  logic             out_valid_q, taken_q, flush_q;
  logic             in_ready_c, take_c, accept_c, handshake_c, halt_hit_c;

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    take_c      = 1'b0;
    accept_c    = 1'b0;
    handshake_c = 1'b0;
    halt_hit_c  = 1'b0;
    pc_nxt      = pc_q;

    // Combinational ready lets fetch drain and execute refill in one cycle.
    in_ready_c  = (state == RUN) && (!out_valid_q || bus.out_ready);
    take_c      = bus.is_c & ((bus.jmp[2] & bus.alu_ng) |
                              (bus.jmp[1] & bus.alu_zr) |
                              (bus.jmp[0] & ~bus.alu_zr & ~bus.alu_ng));
    accept_c    = bus.in_valid && in_ready_c;
    handshake_c = out_valid_q && bus.out_ready;
    halt_hit_c  = accept_c && take_c && (bus.target == issued_q);
    pc_nxt      = take_c ? bus.target : pc_q + ONE;

    case (state)
      RUN:     if (halt_hit_c) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      issued_q    <= RESET_VECTOR;
      out_valid_q <= 1'b1;
      taken_q     <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      if (handshake_c) issued_q <= pc_q;
      // A new instruction overrides the drain of the old pc.
      if (accept_c) begin
        pc_q        <= pc_nxt;
        taken_q     <= take_c;
        out_valid_q <= 1'b1;
      end else if (handshake_c) begin
        out_valid_q <= 1'b0;
      end
      flush_q <= accept_c && take_c;
    end
  end

`ifdef HACK_PC_BRANCH_CNT_EN
  logic [WIDTH-1:0] branch_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      branch_cnt_q <= '0;
    else if (accept_c && take_c && (branch_cnt_q != '1))
      branch_cnt_q <= branch_cnt_q + ONE;
  end

  assign branch_cnt = branch_cnt_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.pc        = pc_q;
  assign bus.taken     = taken_q;
  assign bus.flush     = flush_q;
  assign halted        = (state == HALTED);

endmodule

// File: tb/tb_hack_pc_stage.sv
// Bench for hack_pc_stage: constant vector tables, a halt/reset sequence and
// randomized traffic against a behavioural model of the PC rules.
module tb_hack_pc_stage;
  localparam int W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic halted;
`ifdef HACK_PC_BRANCH_CNT_EN
  logic [W-1:0] branch_cnt;
`endif

  hack_pc_stage_if #(.WIDTH(W)) bus ();

  hack_pc_stage #(
    .WIDTH(W),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .halted(halted)
`ifdef HACK_PC_BRANCH_CNT_EN
    ,
    .branch_cnt(branch_cnt)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         iv, c;
    logic [2:0]   j;
    logic         zr, ng;
    logic [W-1:0] tgt;
    logic         ordy;
    logic         rdy;
    logic [W-1:0] pc;
    logic         ov, tk, fl, hl;
  } vec_t;

  vec_t seq[$];

  function automatic vec_t mk(input logic iv, input logic c, input logic [2:0] j,
                              input logic zr, input logic ng, input logic [W-1:0] tgt,
                              input logic ordy, input logic rdy, input logic [W-1:0] pc,
                              input logic ov, input logic tk, input logic fl, input logic hl);
    vec_t v;
    v.iv = iv; v.c = c; v.j = j; v.zr = zr; v.ng = ng; v.tgt = tgt; v.ordy = ordy;
    v.rdy = rdy; v.pc = pc; v.ov = ov; v.tk = tk; v.fl = fl; v.hl = hl;
    return v;
  endfunction

  task automatic apply(input logic iv, input logic c, input logic [2:0] j, input logic zr,
                       input logic ng, input logic [W-1:0] tgt, input logic ordy);
    bus.in_valid  = iv;
    bus.is_c      = c;
    bus.jmp       = j;
    bus.alu_zr    = zr;
    bus.alu_ng    = ng;
    bus.target    = tgt;
    bus.out_ready = ordy;
  endtask

  task automatic run_seq(input string tag);
    foreach (seq[i]) begin
      apply(seq[i].iv, seq[i].c, seq[i].j, seq[i].zr, seq[i].ng, seq[i].tgt, seq[i].ordy);
      #1;
      chk1($sformatf("%s%0d_in_ready", tag, i), bus.in_ready, seq[i].rdy);
      @(posedge clock);
      #1;
      chkw($sformatf("%s%0d_pc", tag, i), bus.pc, seq[i].pc);
      chk1($sformatf("%s%0d_out_valid", tag, i), bus.out_valid, seq[i].ov);
      chk1($sformatf("%s%0d_taken", tag, i), bus.taken, seq[i].tk);
      chk1($sformatf("%s%0d_flush", tag, i), bus.flush, seq[i].fl);
      chk1($sformatf("%s%0d_halted", tag, i), halted, seq[i].hl);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chkw({tag, "_pc"}, bus.pc, 16'h0000);
    chk1({tag, "_out_valid"}, bus.out_valid, 1'b1);
    chk1({tag, "_taken"}, bus.taken, 1'b0);
    chk1({tag, "_flush"}, bus.flush, 1'b0);
    chk1({tag, "_halted"}, halted, 1'b0);
`ifdef HACK_PC_BRANCH_CNT_EN
    chkw({tag, "_branch_cnt"}, branch_cnt, 16'h0000);
`endif
  endtask

  // Ends at posedge+1, the point where every sequence drives its next inputs.
  task automatic do_reset();
    apply(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Behavioural model: state of the pipeline as seen from outside.
  logic [W-1:0] m_pc, m_issued;
  logic         m_ov, m_taken, m_flush, m_halted;
  int unsigned  m_cnt;

  task automatic model_reset();
    m_pc = 16'h0000; m_issued = 16'h0000; m_ov = 1'b1;
    m_taken = 1'b0; m_flush = 1'b0; m_halted = 1'b0; m_cnt = 0;
  endtask

  // Hack jumps compare the ALU result against zero; bits select lt / eq / gt.
  function automatic logic jump_wanted(input logic c, input logic [2:0] j,
                                       input logic zr, input logic ng);
    logic lt, eq, gt;
    lt = ng;
    eq = zr;
    gt = !zr && !ng;
    return c && ((j[2] && lt) || (j[1] && eq) || (j[0] && gt));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic iv, c, zr, ng, ordy, rdy, tk, acc;
    logic [2:0] j;
    logic [W-1:0] tgt, new_issued;
    int halted_cycles;

    do_reset();
    chk_reset_state("rst");

    seq.delete();
    seq.push_back(mk(1'b0,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0000,1'b0,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0001,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0002,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0003,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b001,1'b0,1'b0,16'h0040,1'b1, 1'b1,16'h0040,1'b1,1'b1,1'b1,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b001,1'b0,1'b1,16'h0080,1'b1, 1'b1,16'h0041,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b0,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0041,1'b0,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b010,1'b1,1'b0,16'h0100,1'b0, 1'b1,16'h0100,1'b1,1'b1,1'b1,1'b0));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0100,1'b1,1'b1,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b000,1'b1,1'b1,16'h0200,1'b1, 1'b1,16'h0101,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b100,1'b1,1'b1,16'hFFFF,1'b1, 1'b1,16'hFFFF,1'b1,1'b1,1'b1,1'b0));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0000,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b0,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0000,1'b0,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b001,1'b0,1'b0,16'h0010,1'b1, 1'b1,16'h0010,1'b1,1'b1,1'b1,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b011,1'b1,1'b0,16'h0020,1'b1, 1'b1,16'h0020,1'b1,1'b1,1'b1,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b101,1'b1,1'b0,16'h0030,1'b1, 1'b1,16'h0021,1'b1,1'b0,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b110,1'b0,1'b0,16'h0050,1'b1, 1'b1,16'h0022,1'b1,1'b0,1'b0,1'b0));
    run_seq("tbl");
`ifdef HACK_PC_BRANCH_CNT_EN
    chkw("tbl_branch_cnt", branch_cnt, 16'd5);
`endif

    // Jump-to-self: issued_pc becomes 0x0010, then a jump there halts.
    do_reset();
    seq.delete();
    seq.push_back(mk(1'b1,1'b1,3'b111,1'b0,1'b0,16'h0010,1'b1, 1'b1,16'h0010,1'b1,1'b1,1'b1,1'b0));
    seq.push_back(mk(1'b0,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0010,1'b0,1'b1,1'b0,1'b0));
    seq.push_back(mk(1'b1,1'b1,3'b111,1'b0,1'b0,16'h0010,1'b0, 1'b1,16'h0010,1'b1,1'b1,1'b1,1'b1));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0010,1'b1,1'b1,1'b0,1'b1));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0010,1'b1,1'b1,1'b0,1'b1));
    seq.push_back(mk(1'b1,1'b0,3'b000,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'h0010,1'b0,1'b1,1'b0,1'b1));
    for (int k = 0; k < 4; k++)
      seq.push_back(mk(1'b1,1'b1,3'b111,1'b0,1'b0,16'h0020,1'b1, 1'b0,16'h0010,1'b0,1'b1,1'b0,1'b1));
    run_seq("halt");
`ifdef HACK_PC_BRANCH_CNT_EN
    chkw("halt_branch_cnt", branch_cnt, 16'd2);
`endif
    reset = 1'b1;
    #1;
    chk_reset_state("async_rst");
    chk1("async_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clock);
    #1 reset = 1'b0;

`ifdef HACK_PC_BRANCH_CNT_EN
    do_reset();
    force dut.branch_cnt_q = 16'hFFFD;
    #1 release dut.branch_cnt_q;
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0100 + 16'(k), 1'b1);
      @(posedge clock);
      #1;
      chkw($sformatf("sat%0d_branch_cnt", k), branch_cnt, (k == 0) ? 16'hFFFE : 16'hFFFF);
    end
`endif

    do_reset();
    model_reset();
    halted_cycles = 0;
    for (int n = 0; n < 800; n++) begin
      if ((m_halted && halted_cycles > 5) || ($urandom_range(0, 99) == 0)) begin
        reset = 1'b1;
        #1;
        chk_reset_state($sformatf("rnd%0d_rst", n));
        model_reset();
        halted_cycles = 0;
        #1 reset = 1'b0;
      end
      iv   = ($urandom_range(0, 3) != 0);
      c    = 1'($urandom_range(0, 1));
      j    = 3'($urandom_range(0, 7));
      zr   = 1'($urandom_range(0, 1));
      ng   = 1'($urandom_range(0, 1));
      tgt  = ($urandom_range(0, 5) == 0) ? m_issued : 16'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      apply(iv, c, j, zr, ng, tgt, ordy);

      rdy = !m_halted && (!m_ov || ordy);
      #1;
      chk1($sformatf("rnd%0d_in_ready", n), bus.in_ready, rdy);
      @(posedge clock);

      acc = iv && rdy;
      tk  = jump_wanted(c, j, zr, ng);
      new_issued = (m_ov && ordy) ? m_pc : m_issued;
      if (acc) begin
        if (tk && tgt == m_issued) m_halted = 1'b1;
        m_pc    = tk ? tgt : m_pc + 16'd1;
        m_taken = tk;
        m_ov    = 1'b1;
        if (tk && m_cnt < 32'hFFFF) m_cnt++;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      m_flush  = acc && tk;
      m_issued = new_issued;
      if (m_halted) halted_cycles++;

      #1;
      chkw($sformatf("rnd%0d_pc", n), bus.pc, m_pc);
      chk1($sformatf("rnd%0d_out_valid", n), bus.out_valid, m_ov);
      chk1($sformatf("rnd%0d_taken", n), bus.taken, m_taken);
      chk1($sformatf("rnd%0d_flush", n), bus.flush, m_flush);
      chk1($sformatf("rnd%0d_halted", n), halted, m_halted);
`ifdef HACK_PC_BRANCH_CNT_EN
      chkw($sformatf("rnd%0d_branch_cnt", n), branch_cnt, 16'(m_cnt));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
